// File: rtl/rx_os_lane_aggregator_pkg.sv
// rx_os_lane_aggregator_pkg: FSM encodings, error-counter width and popcount helper for the lane aggregator.
package rx_os_lane_aggregator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int ERR_W = 8;

   function automatic int popcount(input logic [31:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/os_lane_counter.sv
// os_lane_counter: masked ordered-set compare with a saturating consecutive-match counter per lane.
// RX_OS_ERRCNT_EN adds an 8-bit saturating mismatch counter; otherwise err_count is tied to 0.
module os_lane_counter
   import rx_os_lane_aggregator_pkg::*;
#(
   parameter int OS_WIDTH  = 128,
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 lane_en,
   input  logic [CNT_WIDTH-1:0] thr,
   input  logic [OS_WIDTH-1:0]  os,
   input  logic [OS_WIDTH-1:0]  pattern,
   input  logic [OS_WIDTH-1:0]  mask,
   output logic                 lane_ok,
   output logic [ERR_W-1:0]     err_count
);

   logic [CNT_WIDTH-1:0] cnt;
   logic                 match;

   assign match   = ((os ^ pattern) & mask) == '0;
   assign lane_ok = lane_en && (cnt >= thr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear || !lane_en)
         cnt <= '0;
      else if (en)
         cnt <= !match ? '0 : (cnt >= thr) ? thr : cnt + CNT_WIDTH'(1);
   end

`ifdef RX_OS_ERRCNT_EN
   logic [ERR_W-1:0] err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err <= '0;
      else if (clear)
         err <= '0;
      else if (en && lane_en && !match && err != '1)
         err <= err + ERR_W'(1);
   end

   assign err_count = err;
`else
   assign err_count = '0;
`endif

endmodule

// File: rtl/rx_os_lane_aggregator.sv
// rx_os_lane_aggregator: per-lane ordered-set match counting with a consensus/timeout FSM for the Rx LTSSM.
// Optional per-lane mismatch counters are enabled by defining RX_OS_ERRCNT_EN.
module rx_os_lane_aggregator
   import rx_os_lane_aggregator_pkg::*;
#(
   parameter int NUM_LANES   = 16,
   parameter int OS_WIDTH    = 128,
   parameter int CNT_WIDTH   = 5,
   parameter int TIMER_WIDTH = 24,
   localparam int LN_W       = $clog2(NUM_LANES + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [CNT_WIDTH-1:0]          required_count,
   input  logic [NUM_LANES-1:0]          lane_mask,
   input  logic [LN_W-1:0]               min_lanes,
   input  logic [TIMER_WIDTH-1:0]        timeout_cycles,
   input  logic                          os_valid,
   input  logic [NUM_LANES*OS_WIDTH-1:0] os_data,
   input  logic [OS_WIDTH-1:0]           match_pattern,
   input  logic [OS_WIDTH-1:0]           match_mask,
   output logic                          busy,
   output logic                          done,
   output logic                          success,
   output logic                          timed_out,
   output logic [NUM_LANES-1:0]          lane_ok,
   output logic [OS_WIDTH-1:0]           matched_os,
   output logic [NUM_LANES*ERR_W-1:0]    err_count
);

   state_t                 state, state_nx;
   logic [TIMER_WIDTH-1:0] timer;
   logic [CNT_WIDTH-1:0]   thr;
   logic [OS_WIDTH-1:0]    pick;
   logic                   go, beat, consensus, expired, finish;
   int                     ok_cnt, mask_cnt, need;

   assign thr     = (required_count == '0) ? CNT_WIDTH'(1) : required_count;
   assign go      = (state == IDLE) && start && !abort;
   assign beat    = (state == COLLECT) && os_valid;
   assign expired = (timeout_cycles != '0) && (timer == timeout_cycles - TIMER_WIDTH'(1));
   assign finish  = (state == COLLECT) && !abort && (consensus || expired);
   assign busy    = state != IDLE;
   assign done    = state == DONE;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      os_lane_counter #(
         .OS_WIDTH (OS_WIDTH),
         .CNT_WIDTH(CNT_WIDTH)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .clear    (go),
         .en       (beat),
         .lane_en  (lane_mask[l]),
         .thr      (thr),
         .os       (os_data[l*OS_WIDTH +: OS_WIDTH]),
         .pattern  (match_pattern),
         .mask     (match_mask),
         .lane_ok  (lane_ok[l]),
         .err_count(err_count[l*ERR_W +: ERR_W])
      );
   end

   always_comb begin
      ok_cnt    = popcount(32'(lane_ok));
      mask_cnt  = popcount(32'(lane_mask));
      need      = (min_lanes == '0) ? mask_cnt : int'(min_lanes);
      consensus = (lane_mask != '0) && (ok_cnt >= need);
   end

   // Lowest-index ok lane wins; its live os_data is what gets latched.
   always_comb begin
      pick = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--)
         if (lane_ok[i]) pick = os_data[i*OS_WIDTH +: OS_WIDTH];
   end

   always_comb begin
      state_nx = abort            ? IDLE :
                 state == IDLE    ? (start ? COLLECT : IDLE) :
                 state == COLLECT ? ((consensus || expired) ? DONE : COLLECT) :
                                    IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         success    <= 1'b0;
         timed_out  <= 1'b0;
         matched_os <= '0;
      end else begin
         state <= state_nx;
         if (go) begin
            timer     <= '0;
            success   <= 1'b0;
            timed_out <= 1'b0;
         end else if (state == COLLECT) begin
            timer <= timer + TIMER_WIDTH'(1);
         end
         if (finish) begin
            success   <= consensus;
            timed_out <= !consensus;
            if (consensus) matched_os <= pick;
         end
      end
   end

endmodule

// File: tb/tb_rx_os_lane_aggregator.sv
// tb_rx_os_lane_aggregator: scoreboard bench for the ordered-set lane aggregator (default 16 lanes x 128 bits).
// Error-counter checks follow RX_OS_ERRCNT_EN.
module tb_rx_os_lane_aggregator;

   localparam int NL  = 16;
   localparam int OW  = 128;
   localparam logic [OW-1:0] PAT   = 128'hBC1C_1C1C_0F0F_F0F0_5A5A_A5A5_1234_0000;
   localparam logic [OW-1:0] MMASK = ~128'hFFFF;

   typedef struct {
      logic          succ;
      logic          tmo;
      logic [NL-1:0] ok;
      logic [OW-1:0] mos;
      int            cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start, abort, os_valid;
   logic [4:0]      required_count;
   logic [NL-1:0]   lane_mask;
   logic [4:0]      min_lanes;
   logic [23:0]     timeout_cycles;
   logic [NL*OW-1:0] os_data;
   logic [OW-1:0]   match_pattern, match_mask;
   logic            busy, done, success, timed_out;
   logic [NL-1:0]   lane_ok;
   logic [OW-1:0]   matched_os;
   logic [NL*8-1:0] err_count;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   logic [7:0] tag = 8'h00;
   exp_t sb[$];

   rx_os_lane_aggregator #(
      .NUM_LANES(NL), .OS_WIDTH(OW), .CNT_WIDTH(5), .TIMER_WIDTH(24)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .required_count(required_count), .lane_mask(lane_mask), .min_lanes(min_lanes),
      .timeout_cycles(timeout_cycles), .os_valid(os_valid), .os_data(os_data),
      .match_pattern(match_pattern), .match_mask(match_mask), .busy(busy), .done(done),
      .success(success), .timed_out(timed_out), .lane_ok(lane_ok), .matched_os(matched_os),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] good(input int i);
      return PAT | {112'b0, tag, 8'(i)};
   endfunction

   function automatic logic [OW-1:0] bad(input int i);
      return good(i) ^ (128'h1 << 100);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_data(input logic [NL-1:0] good_lanes);
      for (int i = 0; i < NL; i++)
         os_data[i*OW +: OW] = good_lanes[i] ? good(i) : bad(i);
   endtask

   task automatic beat(input logic [NL-1:0] good_lanes);
      set_data(good_lanes);
      os_valid = 1'b1;
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL early_done cycle %0d: done=%b required 0", cyc, done);
      end
   endtask

   task automatic start_win();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input logic s, input logic t, input logic [NL-1:0] ok, input logic [OW-1:0] mos, input int c);
      exp_t e;
      e.succ = s; e.tmo = t; e.ok = ok; e.mos = mos; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string name);
      exp_t e;
      logic seen;
      seen = 1'b0;
      os_valid = 1'b0;
      e = sb.pop_front();
      for (int k = 0; k < 300 && !seen; k++) begin
         tick();
         seen = done;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_done: no done within 300 cycles, required one at cycle %0d", name, e.cyc);
      end else begin
         if (cyc !== e.cyc) begin
            fails++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cyc, e.cyc);
         end
         tests++;
         if (success !== e.succ) begin
            fails++;
            $display("FAIL %s_success: got %b required %b", name, success, e.succ);
         end
         tests++;
         if (timed_out !== e.tmo) begin
            fails++;
            $display("FAIL %s_timed_out: got %b required %b", name, timed_out, e.tmo);
         end
         tests++;
         if (lane_ok !== e.ok) begin
            fails++;
            $display("FAIL %s_lane_ok: got %h required %h", name, lane_ok, e.ok);
         end
         tests++;
         if (matched_os !== e.mos) begin
            fails++;
            $display("FAIL %s_matched_os: got %h required %h", name, matched_os, e.mos);
         end
         tick();
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse: done=%b busy=%b one cycle later, required 0 0", name, done, busy);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; os_valid = 1'b0;
      required_count = 5'd8; lane_mask = 16'hFFFF; min_lanes = 5'd0; timeout_cycles = 24'd0;
      match_pattern = PAT; match_mask = MMASK;
      set_data(16'hFFFF);
      tick(); tick();
      tests++;
      if ({busy, done, success, timed_out} !== 4'b0 || lane_ok !== '0 || matched_os !== '0 || err_count !== '0) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b succ=%b tmo=%b ok=%h mos=%h, required all 0",
                  busy, done, success, timed_out, lane_ok, matched_os);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_defaults();
      tag = 8'h01;
      start_win();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_collect: got %b required 1", busy);
      end
      for (int b = 0; b < 8; b++) beat(16'hFFFF);
      push(1'b1, 1'b0, 16'hFFFF, good(0), cyc + 1);
      wait_done("defaults");
   endtask

   task automatic test_lane3_break();
      tag = 8'h02;
      start_win();
      for (int b = 0; b < 4; b++) beat(16'hFFFF);
      beat(16'hFFF7);
      for (int b = 0; b < 8; b++) beat(16'hFFFF);
      push(1'b1, 1'b0, 16'hFFFF, good(0), cyc + 1);
      wait_done("lane3_break");
   endtask

   task automatic test_min_lanes();
      tag = 8'h03;
      min_lanes = 5'd4;
      start_win();
      for (int b = 0; b < 8; b++) beat(16'h000F);
      push(1'b1, 1'b0, 16'h000F, good(0), cyc + 1);
      wait_done("min_lanes");
      min_lanes = 5'd0;
   endtask

   task automatic test_timeout();
      logic [OW-1:0] prev;
      prev = good(0);
      tag = 8'h04;
      timeout_cycles = 24'd100;
      start_win();
      push(1'b0, 1'b1, 16'h0000, prev, cyc + 100);
      wait_done("timeout");
   endtask

   task automatic test_tie();
      tag = 8'h05;
      timeout_cycles = 24'd10;
      start_win();
      tick();
      for (int b = 0; b < 8; b++) beat(16'hFFFF);
      push(1'b1, 1'b0, 16'hFFFF, good(0), cyc + 1);
      wait_done("tie");
      timeout_cycles = 24'd0;
   endtask

   task automatic test_boundaries();
      tag = 8'h06;
      required_count = 5'd0;
      start_win();
      beat(16'hFFFF);
      push(1'b1, 1'b0, 16'hFFFF, good(0), cyc + 1);
      wait_done("req_zero");
      required_count = 5'd8;
      lane_mask = 16'h0000;
      timeout_cycles = 24'd20;
      start_win();
      push(1'b0, 1'b1, 16'h0000, good(0), cyc + 20);
      for (int b = 0; b < 8; b++) beat(16'hFFFF);
      wait_done("mask_zero");
      lane_mask = 16'hFFFF;
      timeout_cycles = 24'd0;
   endtask

   task automatic test_abort_reset();
      tag = 8'h07;
      start_win();
      for (int b = 0; b < 3; b++) beat(16'hFFFF);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
      end
      for (int b = 0; b < 10; b++) beat(16'hFFFF);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_over_start: busy=%b required 0", busy);
      end
      start_win();
      for (int b = 0; b < 5; b++) beat(16'hFFFF);
      #2 reset = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || lane_ok !== '0 || success !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b ok=%h succ=%b required 0 0000 0", busy, lane_ok, success);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      tag = 8'h08;
      start_win();
      for (int b = 0; b < 8; b++) beat(16'hFFFF);
      push(1'b1, 1'b0, 16'hFFFF, good(0), cyc + 1);
      wait_done("restart");
   endtask

   task automatic test_err_count();
      start_win();
`ifdef RX_OS_ERRCNT_EN
      for (int b = 0; b < 300; b++) beat(16'hFFFB);
      tests++;
      if (err_count[2*8 +: 8] !== 8'd255 || err_count[0 +: 8] !== 8'd0) begin
         fails++;
         $display("FAIL err_sat: lane2=%0d lane0=%0d required 255 0", err_count[2*8 +: 8], err_count[0 +: 8]);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start_win();
      tests++;
      if (err_count[2*8 +: 8] !== 8'd0) begin
         fails++;
         $display("FAIL err_clear: lane2=%0d required 0", err_count[2*8 +: 8]);
      end
`else
      for (int b = 0; b < 5; b++) beat(16'hFFFB);
      tests++;
      if (err_count !== '0) begin
         fails++;
         $display("FAIL err_tied: got %h required 0", err_count);
      end
`endif
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_lane3_break();
      test_min_lanes();
      test_timeout();
      test_tie();
      test_boundaries();
      test_abort_reset();
      test_err_count();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
